// File: rtl/serial_add_sub_unit.sv
// serial_add_sub_unit
//   Multi-cycle two's-complement adder/subtractor. Each clock processes
//   BITS_PER_CYCLE operand bits, LSB first, through a ripple chain of
//   full-adder cells. Subtraction is a + ~b + 1: b is inverted when the
//   operands are latched, and the carry register is seeded with 1.
//   The unit uses a start/busy/done handshake and reports carry-out and
//   signed overflow.
//   Optional feature macro: SERIAL_ADD_SUB_SAT_EN. When it is defined, a
//   signed overflow on the final step saturates the result to the signed
//   extreme. When it is undefined, the result wraps modulo 2^WIDTH.
module serial_add_sub_unit #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int BPC   = BITS_PER_CYCLE;
    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;        // operand A shift register
    logic [WIDTH-1:0] r_b;        // effective operand B (already inverted for sub)
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    logic [BPC:0]     w_c;        // ripple carries through this step's cells
    logic [BPC-1:0]   w_sum;
    logic [WIDTH-1:0] w_res_shift;
    logic [WIDTH-1:0] w_res_final;
    logic             w_last;
    logic             w_ovf_step;

    assign w_c[0] = r_carry;

    // Ripple chain of full-adder cells over the low bits of both shift registers
    generate
        for (genvar gi = 0; gi < BPC; gi++) begin : g_cell
            assign w_sum[gi]  = r_a[gi] ^ r_b[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (r_a[gi] & r_b[gi]) | (w_c[gi] & (r_a[gi] ^ r_b[gi]));
        end
    endgenerate

    // On the final step the top cell is the MSB, so its carry-in/carry-out
    // give the signed overflow directly.
    assign w_ovf_step = w_c[BPC] ^ w_c[BPC-1];
    assign w_last     = (r_cnt == CNT_W'(STEPS - 1));

    // New sum bits enter result from the MSB side
    generate
        if (BPC == WIDTH) begin : g_shift_full
            assign w_res_shift = w_sum;
        end else begin : g_shift_part
            assign w_res_shift = {w_sum, r_result[WIDTH-1:BPC]};
        end
    endgenerate

`ifdef SERIAL_ADD_SUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    logic r_msb_a;  // sign of operand A; equals sign of effective B whenever ovf=1

    assign w_res_final = (w_last && w_ovf_step) ? (r_msb_a ? SAT_NEG : SAT_POS)
                                                : w_res_shift;
`else
    assign w_res_final = w_res_shift;
`endif

    // Handshake FSM plus serial datapath: accept, step, finish
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
`ifdef SERIAL_ADD_SUB_SAT_EN
            r_msb_a  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b ^ {WIDTH{sub}};
                        r_carry  <= sub;
                        r_cnt    <= '0;
                        r_result <= '0;
                        r_cout   <= 1'b0;
                        r_ovf    <= 1'b0;
`ifdef SERIAL_ADD_SUB_SAT_EN
                        r_msb_a  <= a[WIDTH-1];
`endif
                        r_state  <= S_RUN;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a      <= r_a >> BPC;
                    r_b      <= r_b >> BPC;
                    r_carry  <= w_c[BPC];
                    r_result <= w_res_final;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cout  <= w_c[BPC];
                        r_ovf   <= w_ovf_step;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Testbench for serial_add_sub_unit: an 8-bit/1-bit-per-cycle instance and a
// 16-bit/4-bits-per-cycle instance. Directed cases plus random operations are
// checked against an arithmetic reference model.
module tb_serial_add_sub_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, sub8, start16, sub16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        busy8, done8, cout8, ovf8;
    logic        busy16, done16, cout16, ovf16;
    logic [7:0]  res8;
    logic [15:0] res16;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          wide_sel = 1'b0;
    logic [15:0] last_res;
    logic        last_cout, last_ovf;

    logic        s_busy, s_done, s_cout, s_ovf;
    logic [15:0] s_res;

    always #5 clk = ~clk;

    serial_add_sub_unit #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .cout(cout8), .ovf(ovf8)
    );

    serial_add_sub_unit #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(res16), .cout(cout16), .ovf(ovf16)
    );

    assign s_busy = wide_sel ? busy16 : busy8;
    assign s_done = wide_sel ? done16 : done8;
    assign s_cout = wide_sel ? cout16 : cout8;
    assign s_ovf  = wide_sel ? ovf16  : ovf8;
    assign s_res  = wide_sel ? res16  : {8'h00, res8};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic over w bits
    function automatic void model(input int w, input logic [15:0] ia, input logic [15:0] ib,
                                  input logic is, output logic [15:0] r,
                                  output logic c, output logic o);
        longint m, half, ua, ub, bb, tot, sa, sb, tv;
        m    = (64'sd1 <<< w) - 1;
        half = 64'sd1 <<< (w - 1);
        ua   = longint'(ia) & m;
        ub   = longint'(ib) & m;
        bb   = is ? ((~ub) & m) : ub;
        tot  = ua + bb + (is ? 64'sd1 : 64'sd0);
        r    = 16'(tot & m);
        c    = ((tot >>> w) & 1) != 0;
        sa   = (ua >= half) ? ua - (m + 1) : ua;
        sb   = (ub >= half) ? ub - (m + 1) : ub;
        tv   = is ? (sa - sb) : (sa + sb);
        o    = (tv > half - 1) || (tv < -half);
`ifdef SERIAL_ADD_SUB_SAT_EN
        if (o) r = (tv > 0) ? 16'(half - 1) : 16'(half);
`endif
    endfunction

    task automatic drive_start(input logic [15:0] ia, input logic [15:0] ib, input logic is);
        if (wide_sel) begin
            start16 = 1'b1; a16 = ia; b16 = ib; sub16 = is;
        end else begin
            start8 = 1'b1; a8 = ia[7:0]; b8 = ib[7:0]; sub8 = is;
        end
    endtask

    task automatic clear_start();
        start8  = 1'b0;
        start16 = 1'b0;
    endtask

    // One operation; b2b=1 means the caller is inside the DONE cycle already
    task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic is, input bit b2b);
        int          steps, w, k, busy_cnt;
        logic [15:0] er;
        logic        ec, eo;
        steps = wide_sel ? 4 : 8;
        w     = wide_sel ? 16 : 8;
        if (!b2b) @(negedge clk);
        drive_start(ia, ib, is);
        @(posedge clk); #1;
        clear_start();
        chk("accept_busy", 32'(s_busy), 32'd1);
        chk("accept_res_clr", 32'(s_res), 32'd0);
        k = 0;
        busy_cnt = 0;
        while (!s_done && k < steps + 3) begin
            if (s_busy) busy_cnt++;
            @(posedge clk); #1;
            k++;
        end
        chk("latency", 32'(k), 32'(steps));
        chk("busy_cycles", 32'(busy_cnt), 32'(steps));
        chk("busy_in_done", 32'(s_busy), 32'd0);
        model(w, ia, ib, is, er, ec, eo);
        chk("result", 32'(s_res), 32'(er));
        chk("cout", 32'(s_cout), 32'(ec));
        chk("ovf", 32'(s_ovf), 32'(eo));
        last_res  = s_res;
        last_cout = s_cout;
        last_ovf  = s_ovf;
        $display("op w=%0d a=0x%0h b=0x%0h sub=%0d -> result=0x%0h cout=%0d ovf=%0d (exp 0x%0h %0d %0d)",
                 w, ia, ib, is, s_res, s_cout, s_ovf, er, ec, eo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [15:0] seen_res;
        rst = 1'b1;
        clear_start();
        sub8 = 0; sub16 = 0; a8 = 0; b8 = 0; a16 = 0; b16 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_res8", 32'(res8), 32'd0);
        chk("rst_busy16", 32'(busy16), 32'd0);
        chk("rst_res16", 32'(res16), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic add
        wide_sel = 1'b0;
        do_op(16'd25, 16'd17, 1'b0, 1'b0);
        chk("t1_res", 32'(last_res), 32'd42);
        chk("t1_cout", 32'(last_cout), 32'd0);

        // Subtract, then a back-to-back subtract started in the DONE cycle
        do_op(16'd25, 16'd17, 1'b1, 1'b0);
        chk("t2_res", 32'(last_res), 32'd8);
        chk("t2_cout", 32'(last_cout), 32'd1);
        do_op(16'd17, 16'd25, 1'b1, 1'b1);
        chk("t2b_res", 32'(last_res), 32'hF8);
        chk("t2b_cout", 32'(last_cout), 32'd0);
        @(posedge clk); #1;
        chk("done_width", 32'(done8), 32'd0);
        chk("idle_busy", 32'(busy8), 32'd0);
        chk("res_held", 32'(res8), 32'hF8);

        // Overflow corners
        do_op(16'd100, 16'd100, 1'b0, 1'b0);
        chk("t3_ovf", 32'(last_ovf), 32'd1);
`ifdef SERIAL_ADD_SUB_SAT_EN
        chk("t3_res", 32'(last_res), 32'h7F);
`else
        chk("t3_res", 32'(last_res), 32'hC8);
`endif
        do_op(16'h9C, 16'h9C, 1'b0, 1'b0);
        chk("t3b_cout", 32'(last_cout), 32'd1);
        chk("t3b_ovf", 32'(last_ovf), 32'd1);
`ifdef SERIAL_ADD_SUB_SAT_EN
        chk("t3b_res", 32'(last_res), 32'h80);
`else
        chk("t3b_res", 32'(last_res), 32'h38);
`endif

        // Start re-pulsed while busy must be ignored
        @(negedge clk);
        drive_start(16'd25, 16'd17, 1'b0);
        @(posedge clk); #1;
        clear_start();
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive_start(16'd1, 16'd1, 1'b0);
        @(posedge clk); #1;
        clear_start();
        pulses = 0;
        seen_res = 16'hFFFF;
        for (int i = 0; i < 12; i++) begin
            if (done8) begin
                pulses++;
                seen_res = {8'h00, res8};
            end
            @(posedge clk); #1;
        end
        chk("t4_pulses", 32'(pulses), 32'd1);
        chk("t4_res", 32'(seen_res), 32'd42);
        $display("op ignored-start: pulses=%0d result=0x%0h", pulses, seen_res);

        // Asynchronous reset mid-run
        @(negedge clk);
        drive_start(16'd25, 16'd17, 1'b0);
        @(posedge clk); #1;
        clear_start();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_busy", 32'(busy8), 32'd0);
        chk("t5_done", 32'(done8), 32'd0);
        chk("t5_res", 32'(res8), 32'd0);
        chk("t5_cout", 32'(cout8), 32'd0);
        chk("t5_ovf", 32'(ovf8), 32'd0);
        $display("op reset-mid-run: busy=%0d result=0x%0h", busy8, res8);
        @(negedge clk);
        rst = 1'b0;
        do_op(16'd5, 16'd3, 1'b1, 1'b0);
        chk("t5b_res", 32'(last_res), 32'd2);

        // Random 8-bit operations, some back-to-back
        for (int i = 0; i < 40; i++) begin
            do_op(16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), (i > 0) && ($urandom_range(0, 1) == 1));
        end

        // Wide configuration
        @(negedge clk);
        wide_sel = 1'b1;
        do_op(16'h1234, 16'h0235, 1'b1, 1'b0);
        chk("t6_res", 32'(last_res), 32'h0FFF);
        chk("t6_cout", 32'(last_cout), 32'd1);
        chk("t6_ovf", 32'(last_ovf), 32'd0);
        for (int i = 0; i < 25; i++) begin
            do_op(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 1)), (i > 0) && ($urandom_range(0, 1) == 1));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
